adxl345_spi_target: RTL and testbench

//  Synthesizable SPI target (mode 3) emulating the ADXL345 register interface; the responder
//  for the adxl345 SPI master driver. Used in-fabric for hardware-in-loop and as a DUT

---
 rtl/adxl345_spi_target.sv | 214 +++++++++++++++++++++
 tb/tb_adxl345_spi_target.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/adxl345_spi_target.sv
// ADXL345-compatible SPI target (mode 3, CPOL=1 CPHA=1) with a 64x8 register file.
// The local side loads acceleration samples into 0x32..0x37 and sees every committed
// SPI register write as a one-cycle pulse on wr_valid/wr_addr/wr_data.
module adxl345_spi_target #(
    parameter logic [7:0] DEVID_VALUE = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [47:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        wr_valid,
    output logic [5:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Address 0x00 (device id) and the sample registers are never written over SPI.
    function automatic logic is_read_only(input logic [5:0] a);
        return (a == 6'h00) || ((a >= 6'h32) && (a <= 6'h37));
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_q_r;
    logic                   cs_q_r;

    state_t      state_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_in_r;
    logic [7:0]  shift_out_r;
    logic        rw_r;
    logic        mb_r;
    logic [5:0]  addr_r;
    logic [7:0]  regs_r [64];
    logic        miso_r;
    logic        miso_oe_r;
    logic        sample_ready_r;
    logic        wr_valid_r;
    logic [5:0]  wr_addr_r;
    logic [7:0]  wr_data_r;

    logic        sck_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sck_rise_s;
    logic        sck_fall_s;
    logic        cs_fall_s;
    logic        cs_rise_s;
    logic [7:0]  byte_s;
    logic [5:0]  addr_next_s;

    assign sck_s       = sck_sync_r[SYNC_STAGES-1];
    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s  = sck_s & ~sck_q_r;
    assign sck_fall_s  = ~sck_s & sck_q_r;
    assign cs_fall_s   = ~cs_s & cs_q_r;
    assign cs_rise_s   = cs_s & ~cs_q_r;
    assign byte_s      = {shift_in_r[6:0], mosi_s};
    assign addr_next_s = mb_r ? (addr_r + 6'd1) : addr_r;

    assign miso         = miso_r;
    assign miso_oe      = miso_oe_r;
    assign sample_ready = sample_ready_r;
    assign wr_valid     = wr_valid_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;

    // Synchronise the SPI pins into clk and keep one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_r  <= {SYNC_STAGES{1'b1}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sck_q_r     <= 1'b1;
            cs_q_r      <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
            sck_q_r     <= sck_s;
            cs_q_r      <= cs_s;
        end
    end

    // Transaction FSM, register file, sample loading and write notification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= 3'd0;
            shift_in_r     <= 8'h00;
            shift_out_r    <= 8'h00;
            rw_r           <= 1'b0;
            mb_r           <= 1'b0;
            addr_r         <= 6'd0;
            miso_r         <= 1'b0;
            miso_oe_r      <= 1'b0;
            sample_ready_r <= 1'b0;
            wr_valid_r     <= 1'b0;
            wr_addr_r      <= 6'd0;
            wr_data_r      <= 8'h00;
            for (int i = 0; i < 64; i++) begin
                regs_r[i] <= 8'h00;
            end
            regs_r[6'h00] <= DEVID_VALUE;
            regs_r[6'h2C] <= 8'h0A;
        end else begin
            wr_valid_r     <= 1'b0;
            // A read burst in progress blocks sample updates so all six bytes stay coherent.
            sample_ready_r <= ~((state_r == ST_DATA) && rw_r);

            if (sample_valid && sample_ready_r) begin
                for (int i = 0; i < 6; i++) begin
                    regs_r[6'h32 + 6'(i)] <= sample_data[8*i +: 8];
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_r   <= ST_CMD;
                        bit_cnt_r <= 3'd0;
                        miso_oe_r <= 1'b1;
                        miso_r    <= 1'b0;
                    end else begin
                        miso_r <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (cs_rise_s) begin
                        state_r        <= ST_IDLE;
                        bit_cnt_r      <= 3'd0;
                        miso_r         <= 1'b0;
                        miso_oe_r      <= 1'b0;
                        sample_ready_r <= 1'b1;
                    end else if (sck_rise_s) begin
                        shift_in_r <= byte_s;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_DATA;
                            rw_r    <= byte_s[7];
                            mb_r    <= byte_s[6];
                            addr_r  <= byte_s[5:0];
                            if (byte_s[7]) begin
                                shift_out_r    <= regs_r[byte_s[5:0]];
                                sample_ready_r <= 1'b0;
                            end else begin
                                shift_out_r <= 8'h00;
                            end
                        end else begin
                            state_r <= ST_CMD;
                        end
                    end else begin
                        miso_r <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (cs_rise_s) begin
                        state_r        <= ST_IDLE;
                        bit_cnt_r      <= 3'd0;
                        miso_r         <= 1'b0;
                        miso_oe_r      <= 1'b0;
                        sample_ready_r <= 1'b1;
                    end else if (sck_rise_s) begin
                        shift_in_r <= byte_s;
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            if (!rw_r && !is_read_only(addr_r)) begin
                                regs_r[addr_r] <= byte_s;
                                wr_valid_r     <= 1'b1;
                                wr_addr_r      <= addr_r;
                                wr_data_r      <= byte_s;
                            end else begin
                                wr_valid_r <= 1'b0;
                            end
                            addr_r <= addr_next_s;
                            if (rw_r) begin
                                shift_out_r <= regs_r[addr_next_s];
                            end else begin
                                shift_out_r <= 8'h00;
                            end
                        end else begin
                            addr_r <= addr_r;
                        end
                    end else if (sck_fall_s && rw_r) begin
                        miso_r      <= shift_out_r[7];
                        shift_out_r <= {shift_out_r[6:0], 1'b0};
                    end else begin
                        miso_r <= miso_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    miso_r    <= 1'b0;
                    miso_oe_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adxl345_spi_target.sv
// Randomised self-checking bench for adxl345_spi_target: an SPI mode-3 master drives
// transactions while a register-array model predicts read bytes and write pulses.
module tb_adxl345_spi_target;

    localparam int HALF = 60;  // SCK half period in ns (6 clk cycles)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b1;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [47:0] sample_data = 48'h0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  model [64];
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    logic [13:0] wr_q [$];
    logic [13:0] exp_q [$];

    adxl345_spi_target dut (
        .clk          (clk),
        .rst          (rst),
        .sck          (sck),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    always #5 clk = ~clk;

    // Record every write notification away from the active edge.
    always @(negedge clk) begin
        if (!rst && wr_valid) wr_q.push_back({wr_addr, wr_data});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ro(input logic [5:0] a);
        return (a == 6'h00) || (a >= 6'h32 && a <= 6'h37);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        model[0]  = 8'hE5;
        model[44] = 8'h0A;
    endtask

    // Shift nbits of tx out MSB first; miso is taken just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = tx[7-i];
            #HALF;
            rx[7-i] = miso;
            sck = 1'b1;
            #HALF;
        end
    endtask

    // Full transaction: command byte then nbytes from tx_buf, MISO into rx_buf, then model check.
    task automatic run_xfer(input logic [7:0] cmd, input int nbytes);
        logic [7:0] dummy;
        logic [5:0] a;
        wr_q.delete();
        exp_q.delete();
        cs_n = 1'b0;
        #HALF;
        check_eq("miso_oe_active", {31'd0, miso_oe}, 32'd1);
        spi_bits(cmd, 8, dummy);
        check_eq("miso_zero_in_cmd", {24'd0, dummy}, 32'd0);
        check_eq("sample_ready_in_data", {31'd0, sample_ready}, {31'd0, ~cmd[7]});
        for (int b = 0; b < nbytes; b++) spi_bits(tx_buf[b], 8, rx_buf[b]);
        #HALF;
        cs_n = 1'b1;
        #(2*HALF);
        check_eq("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        a = cmd[5:0];
        for (int b = 0; b < nbytes; b++) begin
            if (cmd[7]) begin
                check_eq($sformatf("read_a%02h", a), {24'd0, rx_buf[b]}, {24'd0, model[a]});
            end else if (!model_ro(a)) begin
                model[a] = tx_buf[b];
                exp_q.push_back({a, tx_buf[b]});
            end
            a = cmd[6] ? a + 6'd1 : a;
        end
        check_eq("wr_count", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check_eq("wr_pulse", {18'd0, wr_q[i]}, {18'd0, exp_q[i]});
    endtask

    task automatic load_sample(input logic [47:0] d);
        logic done;
        done = 1'b0;
        sample_data  = d;
        sample_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sample_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        sample_valid = 1'b0;
        check_eq("sample_accept", {31'd0, done}, 32'd1);
        if (done) for (int i = 0; i < 6; i++) model[6'h32 + 6'(i)] = d[8*i +: 8];
    endtask

    initial begin
        logic [7:0] dummy;
        logic [7:0] cmd;
        int         nb;
        model_reset();

        // Reset values
        #23;
        check_eq("rst_miso", {31'd0, miso}, 32'd0);
        check_eq("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check_eq("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check_eq("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check_eq("rst_sample_ready", {31'd0, sample_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("sample_ready_after_rst", {31'd0, sample_ready}, 32'd1);

        // Device id, single read
        tx_buf[0] = 8'h00;
        run_xfer(8'h80, 1);
        check_eq("devid", {24'd0, rx_buf[0]}, 32'hE5);

        // Writes and readback
        tx_buf[0] = 8'h0B; run_xfer(8'h31, 1);
        tx_buf[0] = 8'h08; run_xfer(8'h2D, 1);
        run_xfer(8'hB1, 1);
        check_eq("rdback_31", {24'd0, rx_buf[0]}, 32'h0B);
        run_xfer(8'hAD, 1);
        check_eq("rdback_2d", {24'd0, rx_buf[0]}, 32'h08);

        // Sample load then burst read of all six data registers
        load_sample(48'h0605_0403_0201);
        run_xfer(8'hF2, 6);
        for (int i = 0; i < 6; i++) check_eq("sample_byte", {24'd0, rx_buf[i]}, i + 1);

        // Burst wrap 0x3E -> 0x01
        run_xfer(8'hFE, 4);
        check_eq("wrap_devid", {24'd0, rx_buf[2]}, 32'hE5);

        // Partial write byte is discarded
        wr_q.delete();
        cs_n = 1'b0;
        #HALF;
        spi_bits(8'h38, 8, dummy);
        spi_bits(8'hFF, 5, dummy);
        #HALF;
        cs_n = 1'b1;
        sck  = 1'b1;
        #(2*HALF);
        check_eq("partial_no_pulse", wr_q.size(), 32'd0);
        run_xfer(8'hB8, 1);
        check_eq("partial_reg38", {24'd0, rx_buf[0]}, 32'h00);

        // Randomised traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) load_sample({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
            cmd = 8'($urandom);
            nb  = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) tx_buf[b] = 8'($urandom);
            run_xfer(cmd, nb);
        end

        // Reset in the middle of a burst read
        load_sample(48'hFFFF_FFFF_FFFF);
        cs_n = 1'b0;
        #HALF;
        spi_bits(8'hF2, 8, dummy);
        spi_bits(8'h00, 8, dummy);
        spi_bits(8'h00, 3, dummy);
        sck  = 1'b0;
        #(HALF/2);
        check_eq("pre_rst_miso", {31'd0, miso}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst_miso", {31'd0, miso}, 32'd0);
        check_eq("midrst_miso_oe", {31'd0, miso_oe}, 32'd0);
        cs_n = 1'b1;
        sck  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        run_xfer(8'hEC, 6);
        check_eq("rst_reg2c", {24'd0, rx_buf[0]}, 32'h0A);
        run_xfer(8'hF2, 6);
        run_xfer(8'hC0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
